gmac_tx_framer: RTL and testbench

Byte-wide GMAC transmit framer between the MAC client stream and the GMII transmit pins. Takes a client payload (destination MAC through end of payload) on a valid/ready/last byte stream, then emits preamble, SFD, payload, zero padding to the Ethernet minimum and the 4-byte FCS, followed by the inter-frame gap. The FCS is produced by an instantiated byte-wide reflected CRC32 engine.

---
 rtl/gmac_pkg.sv | 37 +++
 rtl/gmac_tx_framer_crc.sv | 40 ++++
 rtl/gmac_tx_framer.sv | 197 +++++++++++++++++++
 tb/tb_gmac_tx_framer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmac_pkg.sv
// gmac_pkg: shared types, framing constants and the reflected CRC32 byte step
// used by the GMAC transmit framer.
package gmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int          PREAMBLE_LEN    = 7;
  localparam int          FCS_LEN         = 4;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

  // Bits enter LSB first, matching the order they go out on the wire.
  function automatic logic [31:0] crc32_byte_update(input logic [31:0] crc,
                                                    input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ CRC32_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/gmac_tx_framer_crc.sv
// crc32_ethernet_byte: byte-wide reflected CRC32 engine; fcs is the inverted
// running remainder, ready to transmit least-significant byte first.
module crc32_ethernet_byte
  import gmac_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic [31:0] fcs
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next remainder: init wins over data so a frame always starts clean.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (data_valid) begin
      crc_d = crc32_byte_update(crc_q, data);
    end else begin
      crc_d = crc_q;
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign fcs = ~crc_q;

endmodule

// File: rtl/gmac_tx_framer.sv
// gmac_tx_framer: byte-wide GMII transmit framer (preamble, SFD, payload, pad, FCS, IFG).
// Build option: define GMAC_TX_PAD_EN to zero-pad frames shorter than MIN_PAYLOAD.
module gmac_tx_framer
  import gmac_pkg::*;
#(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

`ifdef GMAC_TX_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  // The IDLE cycle that always follows IFG is itself one idle byte on the wire,
  // so IFG holds one cycle less to keep back-to-back frames IFG_BYTES apart.
  localparam logic [15:0] IFG_LAST = (IFG_BYTES > 1) ? 16'(IFG_BYTES - 2) : 16'd0;

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        underrun_q, underrun_d;

  logic        crc_init;
  logic        crc_valid;
  logic [31:0] fcs;
  logic [15:0] byte_inc;
  logic        short_frame;

  crc32_ethernet_byte u_crc (
    .clk        (clk),
    .rstn       (rstn),
    .init       (crc_init),
    .data_valid (crc_valid),
    .data       (txd_d),
    .fcs        (fcs)
  );

  // Next-state, counters and next output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    byte_cnt_d   = byte_cnt_q;
    txd_d        = 8'h00;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    crc_init     = 1'b0;
    crc_valid    = 1'b0;
    byte_inc     = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
    short_frame  = ({1'b0, byte_cnt_q} + 17'd1) < 17'(MIN_PAYLOAD);

    case (state_q)
      ST_IDLE: begin
        cnt_d      = 16'd0;
        byte_cnt_d = 16'd0;
        if (s_valid) begin
          state_d = ST_PREAMBLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        txd_d   = PREAMBLE_BYTE;
        tx_en_d = 1'b1;
        if (cnt_q == 16'(PREAMBLE_LEN - 1)) begin
          state_d = ST_SFD;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_PREAMBLE;
        end
      end
      ST_SFD: begin
        txd_d    = SFD_BYTE;
        tx_en_d  = 1'b1;
        crc_init = 1'b1;
        state_d  = ST_DATA;
        cnt_d    = 16'd0;
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        cnt_d   = 16'd0;
        if (s_valid) begin
          txd_d      = s_data;
          crc_valid  = 1'b1;
          byte_cnt_d = byte_inc;
          if (s_last) begin
            if (PAD_EN && short_frame) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_FCS;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          // Client starved mid-frame: poison the frame on the wire and give up.
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = ST_IFG;
        end
      end
`ifdef GMAC_TX_PAD_EN
      ST_PAD: begin
        tx_en_d    = 1'b1;
        crc_valid  = 1'b1;
        byte_cnt_d = byte_inc;
        cnt_d      = 16'd0;
        if (short_frame) begin
          state_d = ST_PAD;
        end else begin
          state_d = ST_FCS;
        end
      end
`endif
      ST_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == 16'(FCS_LEN - 1)) begin
          frame_done_d = 1'b1;
          state_d      = ST_IFG;
          cnt_d        = 16'd0;
        end else begin
          state_d = ST_FCS;
        end
      end
      ST_IFG: begin
        if (cnt_q >= IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_IFG;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered GMII/status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      byte_cnt_q   <= 16'd0;
      txd_q        <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign s_ready    = (state_q == ST_DATA);
  assign txd        = txd_q;
  assign tx_en      = tx_en_q;
  assign tx_er      = tx_er_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_gmac_tx_framer.sv
// tb_gmac_tx_framer: directed self-checking bench for gmac_tx_framer; honours GMAC_TX_PAD_EN.
module tb_gmac_tx_framer;

`ifdef GMAC_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int MIN_PAY = 60;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  always #4 clk = ~clk;

  gmac_tx_framer dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .txd        (txd),
    .tx_en      (tx_en),
    .tx_er      (tx_er),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
    logic       fd;
    logic       ur;
    logic       busy;
  } smp_t;

  smp_t       log_q[$];
  logic       cap_en = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay [0:255];
  logic       lst [0:255];
  int n_cmp = 0;
  int n_fail = 0;
  int en_cnt, er_cnt, fd_cnt, ur_cnt, first_en, last_en, fd_idx, er_idx, ur_idx, gap;

  always @(negedge clk) begin
    if (cap_en) log_q.push_back({txd, tx_en, tx_er, frame_done, underrun, busy});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int frame_len(input int n);
    return 8 + ((PAD_EN && n < MIN_PAY) ? MIN_PAY : n) + 4;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  function automatic int first_byte_err();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) return i;
    end
    if (got_q.size() != exp_q.size()) return exp_q.size();
    return -1;
  endfunction

  task automatic fill(input int start, input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) begin
      pay[start+i] = base + 8'(i) * step;
      lst[start+i] = (i == n - 1);
    end
  endtask

  // Expected wire image of one good frame: preamble, SFD, body, bench CRC32.
  task automatic add_exp(input int start, input int n);
    logic [7:0]  body[$];
    logic [31:0] c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) body.push_back(pay[start+i]);
    if (PAD_EN) while (body.size() < MIN_PAY) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[i]) begin
      exp_q.push_back(body[i]);
      c = c ^ {24'h0, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  // Client model; drop_after inserts one s_valid=0 cycle, stop_after returns early.
  task automatic drive(input int total, input int drop_after, input int stop_after);
    int   i = 0;
    int   guard = 0;
    logic hs;
    logic dropped = 1'b0;
    while (i < total && guard < 3000) begin
      if (i == drop_after && !dropped) begin
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; dropped = 1'b1;
      end else begin
        s_valid = 1'b1; s_data = pay[i]; s_last = lst[i];
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (hs) i++;
      if (stop_after >= 0 && i == stop_after) break;
    end
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    if (guard >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL drive_timeout: accepted %0d of %0d bytes", i, total);
    end
  endtask

  task automatic start_capture();
    log_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    cap_en = 1'b1;
  endtask

  task automatic finish_capture();
    int k = 0;
    while (busy !== 1'b0 && k < 600) begin
      @(negedge clk); k++;
    end
    if (k >= 600) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: busy=%b still high after %0d cycles", busy, k);
    end
    repeat (2) @(negedge clk);
    cap_en = 1'b0;
    got_q.delete();
    en_cnt = 0; er_cnt = 0; fd_cnt = 0; ur_cnt = 0;
    first_en = -1; last_en = -1; fd_idx = -1; er_idx = -1; ur_idx = -1; gap = -1;
    foreach (log_q[i]) begin
      if (log_q[i].en) begin
        if (last_en >= 0 && i - last_en > 1 && gap < 0) gap = i - last_en - 1;
        got_q.push_back(log_q[i].txd);
        en_cnt++;
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      if (log_q[i].er) begin er_cnt++; er_idx = i; end
      if (log_q[i].fd) begin fd_cnt++; fd_idx = i; end
      if (log_q[i].ur) begin ur_cnt++; ur_idx = i; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (txd !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h want 00", txd); end
    n_cmp++; if ({tx_en, tx_er} !== 2'b00) begin n_fail++; $display("FAIL reset_en_er: got %b want 00", {tx_en, tx_er}); end
    n_cmp++; if ({busy, frame_done, underrun} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {busy, frame_done, underrun}); end
    n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", s_ready); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, s_ready, tx_en} !== 3'b000) begin n_fail++; $display("FAIL idle_after_reset: got %b want 000", {busy, s_ready, tx_en}); end
  endtask

  task automatic test_short_frame();
    int e;
    fill(0, 9, 8'h31, 8'h01);
    start_capture(); drive(9, -1, -1); finish_capture();
    add_exp(0, 9);
    e = first_byte_err();
    n_cmp++; if (e !== -1) begin n_fail++; $display("FAIL short_bytes: byte %0d got %h want %h", e, got_at(e), exp_at(e)); end
    n_cmp++; if (en_cnt !== frame_len(9)) begin n_fail++; $display("FAIL short_len: got %0d want %0d", en_cnt, frame_len(9)); end
`ifndef GMAC_TX_PAD_EN
    n_cmp++; if (en_cnt !== 21) begin n_fail++; $display("FAIL short_len21: got %0d want 21", en_cnt); end
    n_cmp++;
    if ({got_at(17), got_at(18), got_at(19), got_at(20)} !== 32'h2639_F4CB) begin
      n_fail++; $display("FAIL short_fcs: got %h%h%h%h want 2639F4CB", got_at(17), got_at(18), got_at(19), got_at(20));
    end
`endif
    n_cmp++; if (first_en !== 2) begin n_fail++; $display("FAIL short_latency: got idx %0d want 2", first_en); end
    n_cmp++; if (fd_cnt !== 1 || fd_idx !== last_en) begin n_fail++; $display("FAIL short_done: got %0d pulses at %0d want 1 at %0d", fd_cnt, fd_idx, last_en); end
    n_cmp++; if (er_cnt + ur_cnt !== 0) begin n_fail++; $display("FAIL short_err: got %0d want 0", er_cnt + ur_cnt); end
  endtask

  task automatic test_pad();
    int e;
    fill(0, 14, 8'hA0, 8'h03);
    start_capture(); drive(14, -1, -1); finish_capture();
    add_exp(0, 14);
    e = first_byte_err();
    n_cmp++; if (e !== -1) begin n_fail++; $display("FAIL pad_bytes: byte %0d got %h want %h", e, got_at(e), exp_at(e)); end
`ifdef GMAC_TX_PAD_EN
    n_cmp++; if (en_cnt !== 72) begin n_fail++; $display("FAIL pad_len: got %0d want 72", en_cnt); end
`else
    n_cmp++; if (en_cnt !== 26) begin n_fail++; $display("FAIL nopad_len: got %0d want 26", en_cnt); end
`endif
    n_cmp++; if (fd_idx !== last_en) begin n_fail++; $display("FAIL pad_done: got idx %0d want %0d", fd_idx, last_en); end
  endtask

  task automatic test_long();
    int e;
    fill(0, 64, 8'h01, 8'h07);
    start_capture(); drive(64, -1, -1); finish_capture();
    add_exp(0, 64);
    e = first_byte_err();
    n_cmp++; if (e !== -1) begin n_fail++; $display("FAIL long_bytes: byte %0d got %h want %h", e, got_at(e), exp_at(e)); end
    n_cmp++; if (en_cnt !== 76) begin n_fail++; $display("FAIL long_len: got %0d want 76", en_cnt); end
  endtask

  task automatic test_back_to_back();
    int e;
    fill(0, 5, 8'h10, 8'h11);
    fill(5, 10, 8'hF0, 8'hFD);
    start_capture(); drive(15, -1, -1); finish_capture();
    add_exp(0, 5); add_exp(5, 10);
    e = first_byte_err();
    n_cmp++; if (e !== -1) begin n_fail++; $display("FAIL b2b_bytes: byte %0d got %h want %h", e, got_at(e), exp_at(e)); end
    n_cmp++; if (gap !== 12) begin n_fail++; $display("FAIL b2b_gap: got %0d want 12", gap); end
    n_cmp++; if (fd_cnt !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", fd_cnt); end
    n_cmp++; if (en_cnt !== frame_len(5) + frame_len(10)) begin n_fail++; $display("FAIL b2b_len: got %0d want %0d", en_cnt, frame_len(5) + frame_len(10)); end
  endtask

  task automatic test_underrun();
    int e;
    fill(0, 20, 8'h40, 8'h05);
    lst[19] = 1'b0;
    fill(20, 9, 8'h31, 8'h01);
    start_capture(); drive(29, 20, -1); finish_capture();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 20; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(8'h00);
    add_exp(20, 9);
    e = first_byte_err();
    n_cmp++; if (e !== -1) begin n_fail++; $display("FAIL ur_bytes: byte %0d got %h want %h", e, got_at(e), exp_at(e)); end
    n_cmp++; if (er_cnt !== 1 || er_idx !== 29 + 2 - 1) begin n_fail++; $display("FAIL ur_txer: got %0d at %0d want 1 at 30", er_cnt, er_idx); end
    n_cmp++; if (ur_cnt !== 1 || ur_idx !== er_idx) begin n_fail++; $display("FAIL ur_pulse: got %0d at %0d want 1 at %0d", ur_cnt, ur_idx, er_idx); end
    n_cmp++; if (gap !== 12) begin n_fail++; $display("FAIL ur_ifg: got %0d want 12", gap); end
    n_cmp++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL ur_done: got %0d want 1", fd_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int e;
    fill(0, 30, 8'h77, 8'h01);
    @(posedge clk); #1;
    drive(30, -1, 10);
    n_cmp++; if (tx_en !== 1'b1) begin n_fail++; $display("FAIL mid_active: got tx_en %b want 1", tx_en); end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({txd, tx_en, tx_er, busy, frame_done, underrun, s_ready} !== 14'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want 0000", {txd, tx_en, tx_er, busy, frame_done, underrun, s_ready});
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    fill(0, 9, 8'h31, 8'h01);
    start_capture(); drive(9, -1, -1); finish_capture();
    add_exp(0, 9);
    e = first_byte_err();
    n_cmp++; if (e !== -1) begin n_fail++; $display("FAIL post_reset_bytes: byte %0d got %h want %h", e, got_at(e), exp_at(e)); end
    n_cmp++; if (en_cnt !== frame_len(9) || fd_cnt !== 1) begin n_fail++; $display("FAIL post_reset_frame: got len %0d done %0d want %0d 1", en_cnt, fd_cnt, frame_len(9)); end
  endtask

  initial begin
    test_reset();
    test_short_frame();
    test_pad();
    test_long();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
